// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  rv32i_pkg : RV32I opcode constants, stall-FSM encodings, rs-use decode
//  Revision  : 1.0
// ============================================================================
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_STALL  = 2'd1;
  localparam logic [1:0] ST_FREEZE = 2'd2;

  // Returns {usesRs2, usesRs1} for the given opcode.
  function automatic logic [1:0] rsUse(input logic [6:0] op);
    case (op)
      OP_R, OP_STORE, OP_BRANCH: rsUse = 2'b11;
      OP_I, OP_LOAD, OP_JALR:    rsUse = 2'b01;
      default:                   rsUse = 2'b00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_hazard_detect.sv
`default_nettype none
// ============================================================================
//  id_hazard_detect : decodes rs use in ID and computes the required stall N
//  Revision         : 1.0
// ============================================================================
module id_hazard_detect
  import rv32i_pkg::*;
(
  input  logic [6:0] ID_opcode,
  input  logic [4:0] ID_ReadRegNum1,
  input  logic [4:0] ID_ReadRegNum2,
  input  logic       EX_cntl_RegWrite,
  input  logic       EX_cntl_MemRead,
  input  logic [4:0] EX_WriteRegNum,
  input  logic       MEM_cntl_MemRead,
  input  logic [4:0] MEM_WriteRegNum,
  output logic [1:0] stallN
);

  logic [1:0] w_useRs;
  logic       w_exMatch;
  logic       w_memMatch;
  logic       w_isBranch;

  assign w_useRs = rsUse(ID_opcode);

  // x0 never creates a dependency, so a zero register number cannot match.
  assign w_exMatch  = (w_useRs[0] && (ID_ReadRegNum1 != 5'd0) && (ID_ReadRegNum1 == EX_WriteRegNum)) ||
                      (w_useRs[1] && (ID_ReadRegNum2 != 5'd0) && (ID_ReadRegNum2 == EX_WriteRegNum));
  assign w_memMatch = (w_useRs[0] && (ID_ReadRegNum1 != 5'd0) && (ID_ReadRegNum1 == MEM_WriteRegNum)) ||
                      (w_useRs[1] && (ID_ReadRegNum2 != 5'd0) && (ID_ReadRegNum2 == MEM_WriteRegNum));

  assign w_isBranch = (ID_opcode == OP_BRANCH) || (ID_opcode == OP_JALR);

  // Branches resolve in ID, so they also wait on ALU results and on loads in MEM.
  always_comb begin
    stallN = 2'd0;
    if (w_isBranch) begin
      if (EX_cntl_MemRead && w_exMatch)        stallN = 2'd2;
      else if (EX_cntl_RegWrite && w_exMatch)  stallN = 2'd1;
      else if (MEM_cntl_MemRead && w_memMatch) stallN = 2'd1;
    end else if (EX_cntl_MemRead && w_exMatch) begin
      stallN = 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_stall_controller.sv
`default_nettype none
// ============================================================================
//  id_stall_controller : ID-stage stall/flush FSM with memory-freeze handling
//  Revision            : 1.0
// ============================================================================
module id_stall_controller
  import rv32i_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             ID_opcode,
  input  logic [4:0]             ID_ReadRegNum1,
  input  logic [4:0]             ID_ReadRegNum2,
  input  logic                   EX_cntl_RegWrite,
  input  logic                   EX_cntl_MemRead,
  input  logic [4:0]             EX_WriteRegNum,
  input  logic                   MEM_cntl_MemRead,
  input  logic [4:0]             MEM_WriteRegNum,
  input  logic                   ID_BranchTaken,
  input  logic                   MEM_Stall,
  output logic                   PC_Write,
  output logic                   IFID_Write,
  output logic                   IDEX_Bubble,
  output logic                   IFID_Flush,
  output logic [STALL_CNT_W-1:0] StallCount,
  output logic [1:0]             State
);

  logic [1:0]             r_state;
  logic [1:0]             r_cnt;
  logic [STALL_CNT_W-1:0] r_stallCount;
  logic [1:0]             w_nextState;
  logic [1:0]             w_nextCnt;
  logic [1:0]             w_stallN;

  id_hazard_detect u_hazard (
    .ID_opcode        (ID_opcode),
    .ID_ReadRegNum1   (ID_ReadRegNum1),
    .ID_ReadRegNum2   (ID_ReadRegNum2),
    .EX_cntl_RegWrite (EX_cntl_RegWrite),
    .EX_cntl_MemRead  (EX_cntl_MemRead),
    .EX_WriteRegNum   (EX_WriteRegNum),
    .MEM_cntl_MemRead (MEM_cntl_MemRead),
    .MEM_WriteRegNum  (MEM_WriteRegNum),
    .stallN           (w_stallN)
  );

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    if (reset) begin
      w_nextState = ST_RUN;
      w_nextCnt   = 2'd0;
    end else if (MEM_Stall) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      w_nextState = ST_FREEZE;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_stallN != 2'd0) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            w_nextCnt   = w_stallN - 2'd1;
            w_nextState = (w_stallN > 2'd1) ? ST_STALL : ST_RUN;
          end else begin
            // An unresolved hazard above suppresses the flush implicitly.
            IFID_Flush = ID_BranchTaken;
          end
        end
        ST_STALL: begin
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
          w_nextCnt   = (r_cnt != 2'd0) ? r_cnt - 2'd1 : 2'd0;
          w_nextState = (r_cnt <= 2'd1) ? ST_RUN : ST_STALL;
        end
        ST_FREEZE: begin
          // Release cycle keeps the front end held; the pending stall resumes next.
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          w_nextState = (r_cnt != 2'd0) ? ST_STALL : ST_RUN;
        end
        default: begin
          w_nextState = ST_RUN;
          w_nextCnt   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_cnt        <= 2'd0;
      r_stallCount <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (IDEX_Bubble && (r_stallCount != {STALL_CNT_W{1'b1}}))
        r_stallCount <= r_stallCount + 1'b1;
    end
  end

  assign State      = r_state;
  assign StallCount = r_stallCount;

endmodule
`default_nettype wire

// File: tb/tb_id_stall_controller.sv
`default_nettype none
// ============================================================================
//  tb_id_stall_controller : directed vector table plus multi-cycle sequences
//  Revision               : 1.0
// ============================================================================
module tb_id_stall_controller;

  localparam logic [6:0] C_R   = 7'b0110011;
  localparam logic [6:0] C_I   = 7'b0010011;
  localparam logic [6:0] C_LD  = 7'b0000011;
  localparam logic [6:0] C_ST  = 7'b0100011;
  localparam logic [6:0] C_BR  = 7'b1100011;
  localparam logic [6:0] C_JR  = 7'b1100111;
  localparam logic [6:0] C_LUI = 7'b0110111;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, exRd, memRd;
  logic        exRW, exMR, memMR, brTaken, memStall;
  logic        pcWrite, ifidWrite, bubble, flush;
  logic [15:0] stallCount;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  id_stall_controller #(.STALL_CNT_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .ID_opcode        (opcode),
    .ID_ReadRegNum1   (rs1),
    .ID_ReadRegNum2   (rs2),
    .EX_cntl_RegWrite (exRW),
    .EX_cntl_MemRead  (exMR),
    .EX_WriteRegNum   (exRd),
    .MEM_cntl_MemRead (memMR),
    .MEM_WriteRegNum  (memRd),
    .ID_BranchTaken   (brTaken),
    .MEM_Stall        (memStall),
    .PC_Write         (pcWrite),
    .IFID_Write       (ifidWrite),
    .IDEX_Bubble      (bubble),
    .IFID_Flush       (flush),
    .StallCount       (stallCount),
    .State            (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [4:0] r1, r2;
    logic       eRW, eMR;
    logic [4:0] eRd;
    logic       mMR;
    logic [4:0] mRd;
    logic       br, ms;
    logic       xPcw, xBub, xFlush;
    logic [1:0] xState;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic setIn(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic eRW, input logic eMR, input logic [4:0] eRd,
                       input logic mMR, input logic [4:0] mRd, input logic br, input logic ms);
    opcode = op; rs1 = r1; rs2 = r2; exRW = eRW; exMR = eMR; exRd = eRd;
    memMR = mMR; memRd = mRd; brTaken = br; memStall = ms;
  endtask

  // Asynchronous reset pulse placed mid-cycle, clear of both clock edges.
  task automatic pulseReset();
    @(posedge clk); #1;
    reset = 1'b1; #1;
    reset = 1'b0;
  endtask

  int bubbles;
  int pcLow;

  initial begin
    //            op     r1 r2 eRW eMR eRd mMR mRd br ms  pcw bub fl state
    vecs[0]  = '{C_BR,   5, 0, 1, 1, 5,  0, 0,  0, 0,  0, 1, 0, 2'd1};
    vecs[1]  = '{C_R,    1, 7, 1, 0, 7,  0, 0,  0, 0,  1, 0, 0, 2'd0};
    vecs[2]  = '{C_R,    1, 7, 1, 1, 7,  0, 0,  0, 0,  0, 1, 0, 2'd0};
    vecs[3]  = '{C_BR,   0, 0, 1, 1, 0,  0, 0,  0, 0,  1, 0, 0, 2'd0};
    vecs[4]  = '{C_BR,   1, 2, 1, 0, 9,  0, 0,  1, 0,  1, 0, 1, 2'd0};
    vecs[5]  = '{C_BR,   1, 3, 1, 0, 3,  0, 0,  1, 0,  0, 1, 0, 2'd0};
    vecs[6]  = '{C_BR,   9, 0, 0, 0, 0,  1, 9,  0, 0,  0, 1, 0, 2'd0};
    vecs[7]  = '{C_R,    9, 0, 0, 0, 0,  1, 9,  0, 0,  1, 0, 0, 2'd0};
    vecs[8]  = '{C_I,    1, 4, 1, 1, 4,  0, 0,  0, 0,  1, 0, 0, 2'd0};
    vecs[9]  = '{C_ST,   1, 6, 1, 1, 6,  0, 0,  0, 0,  0, 1, 0, 2'd0};
    vecs[10] = '{C_LUI,  2, 0, 1, 1, 2,  0, 0,  0, 0,  1, 0, 0, 2'd0};
    vecs[11] = '{C_JR,   8, 0, 1, 1, 8,  0, 0,  0, 0,  0, 1, 0, 2'd1};
    vecs[12] = '{C_JR,   8, 0, 1, 0, 8,  0, 0,  1, 0,  0, 1, 0, 2'd0};
    vecs[13] = '{C_BR,   5, 0, 1, 1, 5,  0, 0,  1, 1,  0, 0, 0, 2'd2};
    vecs[14] = '{C_LD,   1, 0, 1, 1, 1,  0, 0,  0, 0,  0, 1, 0, 2'd0};
    vecs[15] = '{C_BR,   5, 0, 0, 0, 5,  0, 5,  0, 0,  1, 0, 0, 2'd0};

    // Reset wins over a concurrent freeze request and a live hazard.
    reset = 1'b1;
    setIn(C_BR, 5, 0, 1, 1, 5, 0, 0, 1, 1);
    #2;
    chk("rst_pcw",   int'(pcWrite),    1);
    chk("rst_ifidw", int'(ifidWrite),  1);
    chk("rst_bub",   int'(bubble),     0);
    chk("rst_flush", int'(flush),      0);
    chk("rst_state", int'(state),      0);
    chk("rst_count", int'(stallCount), 0);
    #10 reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      pulseReset();
      setIn(vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].eRW, vecs[i].eMR, vecs[i].eRd,
            vecs[i].mMR, vecs[i].mRd, vecs[i].br, vecs[i].ms);
      #2;
      chk($sformatf("v%0d_pcw", i),   int'(pcWrite),   int'(vecs[i].xPcw));
      chk($sformatf("v%0d_ifidw", i), int'(ifidWrite), int'(vecs[i].xPcw));
      chk($sformatf("v%0d_bub", i),   int'(bubble),    int'(vecs[i].xBub));
      chk($sformatf("v%0d_flush", i), int'(flush),     int'(vecs[i].xFlush));
      @(posedge clk); #1;
      chk($sformatf("v%0d_state", i), int'(state),      int'(vecs[i].xState));
      chk($sformatf("v%0d_count", i), int'(stallCount), int'(vecs[i].xBub));
    end

    // Branch on a load in EX: two bubbles while the load drains through MEM.
    pulseReset();
    setIn(C_BR, 5, 0, 1, 1, 5, 0, 0, 0, 0);
    bubbles = 0; pcLow = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      bubbles += int'(bubble);
      pcLow   += int'(!pcWrite);
      @(posedge clk); #1;
      if (c == 0) begin
        chk("ld2_state_after1", int'(state), 1);
        setIn(C_BR, 5, 0, 0, 0, 0, 1, 5, 0, 0);
      end else begin
        setIn(C_BR, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      end
    end
    chk("ld2_bubbles", bubbles, 2);
    chk("ld2_pclow",   pcLow,   2);
    chk("ld2_state",   int'(state), 0);
    chk("ld2_count",   int'(stallCount), 2);

    // Taken branch behind a one-cycle hazard: flush lands after the stall.
    pulseReset();
    setIn(C_BR, 1, 3, 1, 0, 3, 0, 0, 1, 0);
    #1;
    chk("brh_flush0", int'(flush),  0);
    chk("brh_bub0",   int'(bubble), 1);
    @(posedge clk); #1;
    setIn(C_BR, 1, 3, 0, 0, 0, 0, 3, 1, 0);
    #1;
    chk("brh_flush1", int'(flush),   1);
    chk("brh_bub1",   int'(bubble),  0);
    chk("brh_pcw1",   int'(pcWrite), 1);

    // Freeze for three cycles while in STALL with one bubble still owed.
    pulseReset();
    setIn(C_BR, 5, 0, 1, 1, 5, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("frz_in_stall", int'(state), 1);
    setIn(C_BR, 5, 0, 0, 0, 0, 1, 5, 0, 1);
    #1;
    chk("frz_pcw",   int'(pcWrite),   0);
    chk("frz_ifidw", int'(ifidWrite), 0);
    chk("frz_bub",   int'(bubble),    0);
    chk("frz_flush", int'(flush),     0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("frz_state%0d", c), int'(state),      2);
      chk($sformatf("frz_count%0d", c), int'(stallCount), 1);
      if (c < 2) chk($sformatf("frz_bubhold%0d", c), int'(bubble), 0);
    end
    setIn(C_BR, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    bubbles = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      bubbles += int'(bubble);
      @(posedge clk); #1;
    end
    chk("frz_release_bubbles", bubbles, 1);
    chk("frz_end_state", int'(state), 0);
    chk("frz_end_count", int'(stallCount), 2);

    // Reset mid-STALL takes effect without a clock edge and leaves no residue.
    pulseReset();
    setIn(C_BR, 5, 0, 1, 1, 5, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("mrst_pre_state", int'(state),      1);
    chk("mrst_pre_count", int'(stallCount), 1);
    #2 reset = 1'b1;
    #1;
    chk("mrst_state", int'(state),      0);
    chk("mrst_count", int'(stallCount), 0);
    chk("mrst_pcw",   int'(pcWrite),    1);
    chk("mrst_bub",   int'(bubble),     0);
    #1 reset = 1'b0;
    setIn(C_BR, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    bubbles = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      bubbles += int'(bubble);
      @(posedge clk); #1;
    end
    chk("mrst_after_bubbles", bubbles, 0);
    chk("mrst_after_count",   int'(stallCount), 0);

    // Continuous one-cycle load-use hazard drives the counter into saturation.
    pulseReset();
    setIn(C_R, 1, 7, 1, 1, 7, 0, 0, 0, 0);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_near",  int'(stallCount), 16'hFFFE);
    @(posedge clk); #1;
    chk("sat_full",  int'(stallCount), 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold",  int'(stallCount), 16'hFFFF);
    chk("sat_bub",   int'(bubble),     1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stall_controller.md
ID_STALL_CONTROLLER -- requirements
Module: id_stall_controller

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 16, the width of the saturating stall-cycle counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port ID_opcode, input, 7, opcode of the instruction in ID.
REQ-005 SHALL have ports ID_ReadRegNum1 and ID_ReadRegNum2, input, 5 each, rs1 and rs2 of the ID instruction.
REQ-006 SHALL have ports EX_cntl_RegWrite and EX_cntl_MemRead, input, 1 each, control bits of the instruction in EX.
REQ-007 SHALL have port EX_WriteRegNum, input, 5, rd of the EX instruction.
REQ-008 SHALL have ports MEM_cntl_MemRead, input, 1, and MEM_WriteRegNum, input, 5, for the MEM instruction.
REQ-009 SHALL have port ID_BranchTaken, input, 1, the ID-stage branch/jalr redirect decision.
REQ-010 SHALL have port MEM_Stall, input, 1, the global memory freeze request.
REQ-011 SHALL have ports PC_Write and IFID_Write, output, 1 each, which hold the PC and IF/ID when low.
REQ-012 SHALL have ports IDEX_Bubble, output, 1, which inserts a NOP into ID/EX, and IFID_Flush, output, 1, which squashes IF/ID.
REQ-013 SHALL have port StallCount, output, STALL_CNT_W, the saturating count of hazard-stall cycles.
REQ-014 SHALL have port State, output, 2, the current FSM state.

Function
REQ-015 SHALL decode rs use from the opcode as follows: 0110011, 0100011 and 1100011 use rs1 and rs2; 0010011, 0000011 and 1100111 use rs1 only; all other opcodes use none.
REQ-016 SHALL treat a register match as valid only if the register is used, the register number is nonzero, and it equals the producer rd.
REQ-017 SHALL compute the required stall N for a branch (1100011) or jalr (1100111) in ID as: EX load match = 2; else EX RegWrite match = 1; else MEM load match = 1; else 0.
REQ-018 SHALL compute the required stall N for any other opcode as: EX load match = 1; else 0.
REQ-019 SHALL implement FSM states RUN=0, STALL=1 and FREEZE=2, with a 2-bit down-counter cnt.
REQ-020 SHALL, in RUN with MEM_Stall low and N>0, combinationally assert the stall (PC_Write=0, IFID_Write=0, IDEX_Bubble=1), load cnt=N-1, go to STALL if N-1>0, and otherwise stay in RUN.
REQ-021 SHALL, in STALL with MEM_Stall low, assert the stall and decrement cnt, returning to RUN in the cycle after cnt reaches 0 so that exactly N stall cycles result.
REQ-022 SHALL re-evaluate hazards on re-entry to RUN.
REQ-023 SHALL, in RUN with N=0 and MEM_Stall low, assert IFID_Flush=ID_BranchTaken for one cycle, with PC_Write=1, IFID_Write=1 and IDEX_Bubble=0.
REQ-024 SHALL give a hazard priority over ID_BranchTaken in the same cycle: flush suppressed, because the branch is unresolved.
REQ-025 SHALL, whenever MEM_Stall is high in any state, drive PC_Write=0, IFID_Write=0, IDEX_Bubble=0 and IFID_Flush=0, enter FREEZE, and hold cnt.
REQ-026 SHALL, on MEM_Stall deasserting, return from FREEZE to STALL if cnt>0, and otherwise to RUN.
REQ-027 SHALL increment StallCount on each cycle with IDEX_Bubble=1, saturating at all-ones with no wrap.
REQ-028 SHALL not count FREEZE cycles in StallCount.

Reset
REQ-029 SHALL, on reset assertion, asynchronously set State=RUN, cnt=0 and StallCount=0.
REQ-030 SHALL hold PC_Write=1, IFID_Write=1, IDEX_Bubble=0 and IFID_Flush=0 while reset is high.
REQ-031 SHALL abandon an in-progress stall on reset mid-stall, resuming with no residual bubbles.

Structure
REQ-032 SHALL take the opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR) and the state encodings from the shared package rv32i_pkg.
REQ-033 SHALL place the rs-use decode and the N computation in the combinational sub-module id_hazard_detect, with the FSM and counters in the top.

Verification
REQ-034 SHALL verify that a branch in ID with rs1=5, EX load rd=5 and MEM_Stall=0 gives exactly 2 cycles of IDEX_Bubble=1 and PC_Write=0, then RUN, with StallCount=2.
REQ-035 SHALL verify that an R-type in ID with rs2=7, EX RegWrite rd=7 and no load gives N=0 with no bubble; with EX load rd=7 instead, exactly 1 bubble.
REQ-036 SHALL verify that a branch with rs1=0 and an EX load rd=0 gives no stall.
REQ-037 SHALL verify that ID_BranchTaken=1 with no hazard gives IFID_Flush=1 for 1 cycle, and that ID_BranchTaken=1 while N=1 gives no flush that cycle and a flush in the cycle after the stall.
REQ-038 SHALL verify that MEM_Stall=1 for 3 cycles during STALL with cnt=1 gives State=FREEZE with all writes low and StallCount unchanged, then 1 further bubble on release.
REQ-039 SHALL verify that reset asserted mid-STALL immediately gives State=0, StallCount=0 and PC_Write=1 without waiting for a clock edge, and that StallCount preloaded near saturation holds at 0xFFFF.
